// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM states and size/byte-mask helpers for lsu_ctrl
package lsu_pkg;

  // Load width codes
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; 0 marks an unused encoding
  function automatic logic [2:0] size_dec(input logic [1:0] width);
    case (width)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Unshifted byte-lane mask for an access of the given size
  function automatic logic [3:0] byte_mask(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Legal width codes differ between loads and stores
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == FNC_SB) || (f3 == FNC_SH) || (f3 == FNC_SW);
    else
      return (f3 == FNC_LB) || (f3 == FNC_LH) || (f3 == FNC_LW) ||
             (f3 == FNC_LBU) || (f3 == FNC_LHU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half/word from merged beats and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed byte down to lane 0, then extend by width code
  always_comb begin
    shifted = 32'(data_i >> {off_i, 3'b000});
    case (funct3_i)
      FNC_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
      FNC_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
      FNC_LW:  data_o = shifted;
      FNC_LBU: data_o = {24'h000000, shifted[7:0]};
      FNC_LHU: data_o = {16'h0000, shifted[15:0]};
      default: data_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer; LSU_SPLIT_EN enables two-beat word-crossing accesses
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              resp_valid_o,
  output logic [4:0]        resp_rd_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_fault_o
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              fault_q;
  logic [31:0]       lo_q;

  logic              handshake;
  logic              req_fault;
  logic [1:0]        off;
  logic [2:0]        size;
  logic [3:0]        mask;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] beat_addr;
  logic [3:0]        beat_be;
  logic [31:0]       beat_wdata;
  logic [63:0]       merged;
  logic [31:0]       load_data;

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign handshake   = req_valid_i && req_ready_o;

  assign off       = addr_q[1:0];
  assign size      = size_dec(funct3_q[1:0]);
  assign mask      = byte_mask(size);
  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_SPLIT_EN
  logic [31:0] hi_q;
  logic        cross;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  // Misalignment is handled by splitting, so only bad width codes fault
  assign req_fault = !funct3_legal(req_we_i, req_funct3_i);

  assign cross   = ({1'b0, off} + size) > 3'd4;
  assign be_wide = {4'b0000, mask} << off;
  assign wd_wide = {32'h00000000, wdata_q} << {off, 3'b000};

  // The second beat takes the upper halves of the same shifts
  assign beat_addr  = (state_q == ST_ACC1) ? base_addr + ADDR_W'(4) : base_addr;
  assign beat_be    = (state_q == ST_ACC1) ? be_wide[7:4] : be_wide[3:0];
  assign beat_wdata = (state_q == ST_ACC1) ? wd_wide[63:32] : wd_wide[31:0];
  assign merged     = {hi_q, lo_q};
`else
  logic [2:0] req_size;

  // Without splitting, any access not naturally aligned faults up front
  assign req_size  = size_dec(req_funct3_i[1:0]);
  assign req_fault = !funct3_legal(req_we_i, req_funct3_i) ||
                     ((req_addr_i[1:0] & (req_size[1:0] - 2'd1)) != 2'b00);

  assign beat_addr  = base_addr;
  assign beat_be    = mask << off;
  assign beat_wdata = wdata_q << {off, 3'b000};
  assign merged     = {32'h00000000, lo_q};
`endif

  lsu_load_align u_align (
    .data_i   (merged),
    .off_i    (off),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  // State register; async reset abandons any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and all handshake/memory/response outputs
  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = 4'b0000;
    mem_wdata_o  = 32'h00000000;
    resp_valid_o = 1'b0;
    resp_rd_o    = 5'd0;
    resp_data_o  = 32'h00000000;
    resp_fault_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) state_d = req_fault ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = beat_addr;
        mem_be_o    = we_q ? beat_be : 4'b0000;
        mem_wdata_o = we_q ? beat_wdata : 32'h00000000;
`ifdef LSU_SPLIT_EN
        if (mem_ack_i) state_d = cross ? ST_ACC1 : ST_RESP;
`else
        if (mem_ack_i) state_d = ST_RESP;
`endif
      end
`ifdef LSU_SPLIT_EN
      ST_ACC1: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = beat_addr;
        mem_be_o    = we_q ? beat_be : 4'b0000;
        mem_wdata_o = we_q ? beat_wdata : 32'h00000000;
        if (mem_ack_i) state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_fault_o = fault_q;
        if (!we_q && !fault_q) begin
          resp_rd_o   = rd_q;
          resp_data_o = load_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields latch on handshake; read beats latch on their ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h00000000;
      rd_q     <= 5'd0;
      fault_q  <= 1'b0;
      lo_q     <= 32'h00000000;
`ifdef LSU_SPLIT_EN
      hi_q     <= 32'h00000000;
`endif
    end else begin
      if (handshake) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        rd_q     <= req_rd_i;
        fault_q  <= req_fault;
        lo_q     <= 32'h00000000;
`ifdef LSU_SPLIT_EN
        hi_q     <= 32'h00000000;
`endif
      end
      if (state_q == ST_ACC0 && mem_ack_i) lo_q <= mem_rdata_i;
`ifdef LSU_SPLIT_EN
      if (state_q == ST_ACC1 && mem_ack_i) hi_q <= mem_rdata_i;
`endif
    end
  end

endmodule
